// File: rtl/gst_dmasnd_pkg.sv
// Shared definitions for the STE DMA sound sequencer (gst_dmasnd_ctrl).
// Optional frame counter register is enabled by GST_DMASND_FRAMECNT_EN.
package gst_dmasnd_pkg;

  localparam logic [4:0] REG_CTRL     = 5'd0;
  localparam logic [4:0] REG_START_HI = 5'd1;
  localparam logic [4:0] REG_START_MI = 5'd2;
  localparam logic [4:0] REG_START_LO = 5'd3;
  localparam logic [4:0] REG_CNT_HI   = 5'd4;
  localparam logic [4:0] REG_CNT_MI   = 5'd5;
  localparam logic [4:0] REG_CNT_LO   = 5'd6;
  localparam logic [4:0] REG_END_HI   = 5'd7;
  localparam logic [4:0] REG_END_MI   = 5'd8;
  localparam logic [4:0] REG_END_LO   = 5'd9;
  localparam logic [4:0] REG_FCNT     = 5'd10;

  localparam int CTRL_PLAY = 0;
  localparam int CTRL_LOOP = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_FETCH,
    ST_LOAD,
    ST_ENDCHK
  } state_t;

  // idx 0 = hi byte, 1 = mid byte, otherwise lo byte of a 24-bit address
  function automatic logic [7:0] addr_byte(input logic [23:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[23:16];
      2'd1:    return v[15:8];
      default: return v[7:0];
    endcase
  endfunction

endpackage

// File: rtl/gst_dmasnd_regs.sv
// CPU-visible register file: write-edge detect, ctrl/start/end storage, read mux.
// GST_DMASND_FRAMECNT_EN adds the 16-bit frame counter at A=10.
module gst_dmasnd_regs
  import gst_dmasnd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic [4:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic        rw_i,
  output logic [15:0] rdata_o,
  input  logic [23:0] cnt_i,
  input  logic        clr_play_i,
  input  logic        sint_i,
  output logic        play_o,
  output logic        loop_o,
  output logic [23:0] start_o,
  output logic [23:0] end_o
);

  logic        cs_q;
  logic        play_q;
  logic        loop_q;
  logic [23:0] start_q;
  logic [23:0] end_q;
  logic        wr_en;
  logic [15:0] rd_mux;
  logic [7:0]  unused_wdata;

  assign unused_wdata = wdata_i[15:8];

  // One write per CS assertion: only the first cycle of CS counts.
  assign wr_en = cs_i & ~cs_q & ~rw_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_q    <= 1'b0;
      play_q  <= 1'b0;
      loop_q  <= 1'b0;
      start_q <= 24'h0;
      end_q   <= 24'h0;
    end else begin
      cs_q <= cs_i;
      // A CPU ctrl write overrides the sequencer's end-of-frame PLAY clear.
      if (wr_en && (addr_i == REG_CTRL)) begin
        play_q <= wdata_i[CTRL_PLAY];
        loop_q <= wdata_i[CTRL_LOOP];
      end else if (clr_play_i) begin
        play_q <= 1'b0;
      end
      if (wr_en) begin
        case (addr_i)
          REG_START_HI: start_q[23:16] <= wdata_i[7:0];
          REG_START_MI: start_q[15:8]  <= wdata_i[7:0];
          REG_START_LO: start_q[7:0]   <= {wdata_i[7:1], 1'b0};
          REG_END_HI:   end_q[23:16]   <= wdata_i[7:0];
          REG_END_MI:   end_q[15:8]    <= wdata_i[7:0];
          REG_END_LO:   end_q[7:0]     <= {wdata_i[7:1], 1'b0};
          default: ;
        endcase
      end
    end
  end

`ifdef GST_DMASND_FRAMECNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q <= 16'h0;
    end else if (wr_en && (addr_i == REG_FCNT)) begin
      fcnt_q <= 16'h0;
    end else if (sint_i) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end
`else
  logic unused_sint;
  assign unused_sint = sint_i;
`endif

  always_comb begin
    rd_mux = 16'h0;
    case (addr_i)
      REG_CTRL:     rd_mux = {14'h0, loop_q, play_q};
      REG_START_HI: rd_mux[7:0] = addr_byte(start_q, 2'd0);
      REG_START_MI: rd_mux[7:0] = addr_byte(start_q, 2'd1);
      REG_START_LO: rd_mux[7:0] = addr_byte(start_q, 2'd2);
      REG_CNT_HI:   rd_mux[7:0] = addr_byte(cnt_i, 2'd0);
      REG_CNT_MI:   rd_mux[7:0] = addr_byte(cnt_i, 2'd1);
      REG_CNT_LO:   rd_mux[7:0] = addr_byte(cnt_i, 2'd2);
      REG_END_HI:   rd_mux[7:0] = addr_byte(end_q, 2'd0);
      REG_END_MI:   rd_mux[7:0] = addr_byte(end_q, 2'd1);
      REG_END_LO:   rd_mux[7:0] = addr_byte(end_q, 2'd2);
`ifdef GST_DMASND_FRAMECNT_EN
      REG_FCNT:     rd_mux = fcnt_q;
`endif
      default:      rd_mux = 16'h0;
    endcase
  end

  assign rdata_o = (cs_i && rw_i) ? rd_mux : 16'h0;
  assign play_o  = play_q;
  assign loop_o  = loop_q;
  assign start_o = start_q;
  assign end_o   = end_q;

endmodule

// File: rtl/gst_dmasnd_ctrl.sv
// STE DMA sound sequencer: fetches frame words in sound slots and strobes them into the shifter FIFO.
// Build option GST_DMASND_FRAMECNT_EN adds a frame counter register (see gst_dmasnd_regs).
//
// state  | meaning
// IDLE   | not playing, waiting for PLAY
// ARM    | latch start/end into cnt/end_l
// WAIT   | playing, waiting for a sound slot with SREQ
// FETCH  | MREQ high, waiting for MACK
// LOAD   | SLOAD_N low for SLOAD_LEN cycles
// ENDCHK | end-of-frame / loop / next-word decision
module gst_dmasnd_ctrl
  import gst_dmasnd_pkg::*;
#(
  parameter int SLOAD_LEN      = 4,
  parameter int WORDS_PER_SLOT = 1
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        CS,
  input  logic [4:0]  A,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RW,
  input  logic        SREQ,
  input  logic        SND_SLOT,
  output logic        MREQ,
  output logic [22:0] MADDR,
  input  logic        MACK,
  output logic        SLOAD_N,
  output logic        SINT,
  output logic        ACTIVE
);

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [23:0] end_l_q;
  logic [2:0]  wcnt_q;
  logic [3:0]  scnt_q;
  logic        mreq_q;
  logic [22:0] maddr_q;
  logic        sload_n_q;
  logic        sint_q;
  logic        active_q;

  logic        play;
  logic        loop_en;
  logic [23:0] start_addr;
  logic [23:0] end_addr;
  logic        frame_done;
  logic        clr_play;
  logic        more_words;

  gst_dmasnd_regs u_regs (
    .clk_i      (clk32),
    .rst_i      (reset),
    .cs_i       (CS),
    .addr_i     (A),
    .wdata_i    (DIN),
    .rw_i       (RW),
    .rdata_o    (DOUT),
    .cnt_i      (cnt_q),
    .clr_play_i (clr_play),
    .sint_i     (sint_q),
    .play_o     (play),
    .loop_o     (loop_en),
    .start_o    (start_addr),
    .end_o      (end_addr)
  );

  assign frame_done = (cnt_q == end_l_q);
  // Combinational so PLAY is already clear when the FSM lands in IDLE.
  assign clr_play   = (state_q == ST_ENDCHK) && frame_done && !loop_en;
  assign more_words = ((wcnt_q + 3'd1) < 3'(WORDS_PER_SLOT));

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 24'h0;
      end_l_q   <= 24'h0;
      wcnt_q    <= 3'd0;
      scnt_q    <= 4'd0;
      mreq_q    <= 1'b0;
      maddr_q   <= 23'h0;
      sload_n_q <= 1'b1;
      sint_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sint_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (play) state_q <= ST_ARM;
        end
        ST_ARM: begin
          cnt_q   <= start_addr;
          end_l_q <= end_addr;
          if (start_addr == end_addr) begin
            state_q <= ST_ENDCHK;
          end else begin
            state_q  <= ST_WAIT;
            active_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!play) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else if (SND_SLOT && SREQ) begin
            state_q <= ST_FETCH;
            wcnt_q  <= 3'd0;
            mreq_q  <= 1'b1;
            maddr_q <= cnt_q[23:1];
          end
        end
        ST_FETCH: begin
          if (MACK) begin
            state_q   <= ST_LOAD;
            mreq_q    <= 1'b0;
            sload_n_q <= 1'b0;
            scnt_q    <= 4'(SLOAD_LEN - 1);
            cnt_q     <= cnt_q + 24'd2;
          end
        end
        ST_LOAD: begin
          if (scnt_q == 4'd0) begin
            sload_n_q <= 1'b1;
            state_q   <= ST_ENDCHK;
          end else begin
            scnt_q <= scnt_q - 4'd1;
          end
        end
        ST_ENDCHK: begin
          if (frame_done) begin
            sint_q <= 1'b1;
            if (loop_en) begin
              state_q <= ST_ARM;
            end else begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
            end
          end else if (!play) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else if (more_words && SREQ) begin
            state_q <= ST_FETCH;
            wcnt_q  <= wcnt_q + 3'd1;
            mreq_q  <= 1'b1;
            maddr_q <= cnt_q[23:1];
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MREQ    = mreq_q;
  assign MADDR   = maddr_q;
  assign SLOAD_N = sload_n_q;
  assign SINT    = sint_q;
  assign ACTIVE  = active_q;

endmodule
